silife_demo_seq: RTL and testbench

SILIFE_DEMO_SEQ -- requirements
Module: silife_demo_seq

---
 rtl/silife_demo_pkg.sv | 37 +++
 rtl/silife_pattern_rom.sv | 28 ++
 rtl/silife_demo_seq.sv | 138 +++++++++++++
 tb/tb_silife_demo_seq.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/silife_demo_pkg.sv
// Shared definitions for the demo sequencer: stored patterns, FSM encoding and default step period.
// Pattern words are row-major with row 0 in the most-significant byte.
package silife_demo_pkg;

  localparam int PAT_ROWS  = 32;
  localparam int PAT_COLS  = 8;
  localparam int PAT_W     = PAT_ROWS * PAT_COLS;
  localparam int PAT_COUNT = 4;

  localparam logic [31:0] DEFAULT_PERIOD = 32'd4_000_000;

  localparam logic [PAT_W-1:0] PATTERN_0 =
    256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [PAT_W-1:0] PATTERN_1 =
    256'h8040201008040201804020100804020180402010080402018040201008040201;
  localparam logic [PAT_W-1:0] PATTERN_2 =
    256'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0EFEEEDECEBEAE9E8E7E6E5E4E3E2E1E0;
  localparam logic [PAT_W-1:0] PATTERN_3 =
    256'hA53CA53CA53CA53CA53CA53CA53CA53CA53CA53CA53CA53CA53CA53CA53CA53C;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  function automatic logic [PAT_W-1:0] pattern_word(input int idx);
    case (idx)
      0:       return PATTERN_0;
      1:       return PATTERN_1;
      2:       return PATTERN_2;
      3:       return PATTERN_3;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/silife_pattern_rom.sv
// Pattern store: maps (sel, row) to one COLS-bit grid row, bit order reversed within the row.
// Purely combinational; no flow control.
module silife_pattern_rom
  import silife_demo_pkg::*;
#(
  parameter int ROWS         = 32,
  parameter int COLS         = 8,
  parameter int NUM_PATTERNS = 4,
  parameter int ROW_W        = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int SEL_W        = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [ROW_W-1:0] row,
  output logic [COLS-1:0]  row_bits
);

  logic [PAT_W-1:0] word;

  always_comb begin
    word     = (int'(sel) < NUM_PATTERNS) ? pattern_word(int'(sel)) : '0;
    row_bits = '0;
    // Shifting rather than indexing keeps out-of-range bits at zero for oversize grids.
    for (int i = 0; i < COLS; i++) begin
      row_bits[i] = 1'(word >> ((ROWS - 1 - int'(row)) * COLS + (COLS - 1 - i)));
    end
  end

endmodule

// File: rtl/silife_demo_seq.sv
// Demo sequencer: writes a stored pattern into the grid row by row, then issues periodic step pulses.
// One row per enabled cycle; en=0 freezes everything and masks wr_en/step.
module silife_demo_seq
  import silife_demo_pkg::*;
#(
  parameter int ROWS         = 32,
  parameter int COLS         = 8,
  parameter int NUM_PATTERNS = 4,
  parameter int PERIOD_W     = 32,
  localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int SEL_W       = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [SEL_W-1:0]    pattern_sel,
  input  logic                reload,
  input  logic                pause,
  input  logic [PERIOD_W-1:0] period,
  output logic [ROW_W-1:0]    row_select,
  output logic [COLS-1:0]     cells,
  output logic                wr_en,
  output logic                step,
  output logic                busy
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t                state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic                  step_q, step_d;
  logic                  busy_q, busy_d;
  logic [PERIOD_W-1:0]   period_m1;

  assign period_m1 = period - PERIOD_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      step_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      step_q  <= step_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    wr_en_d = 1'b0;
    step_d  = 1'b0;

    if (en) begin
      case (state_q)
        IDLE: begin
          state_d = LOAD;
          row_d   = '0;
          sel_d   = pattern_sel;
          wr_en_d = 1'b1;
          cnt_d   = '0;
        end
        LOAD: begin
          if (reload) begin
            row_d   = '0;
            sel_d   = pattern_sel;
            wr_en_d = 1'b1;
            cnt_d   = '0;
          end else if (row_q == LAST_ROW) begin
            state_d = RUN;
            row_d   = '0;
            cnt_d   = '0;
          end else begin
            row_d   = row_q + ROW_W'(1);
            wr_en_d = 1'b1;
          end
        end
        RUN: begin
          // A reload or new selection outranks a coinciding counter expiry.
          if (reload || (pattern_sel != sel_q)) begin
            state_d = LOAD;
            row_d   = '0;
            sel_d   = pattern_sel;
            wr_en_d = 1'b1;
            cnt_d   = '0;
          end else if (!pause && (period != '0)) begin
            // >= also recovers when period shrinks below the running count.
            if (cnt_q >= period_m1) begin
              cnt_d  = '0;
              step_d = (cnt_q == period_m1);
            end else begin
              cnt_d = cnt_q + PERIOD_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          row_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != RUN);
  end

  assign row_select = row_q;
  assign wr_en      = wr_en_q;
  assign step       = step_q;
  assign busy       = busy_q;

  silife_pattern_rom #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .NUM_PATTERNS (NUM_PATTERNS),
    .ROW_W        (ROW_W),
    .SEL_W        (SEL_W)
  ) u_rom (
    .sel      (sel_q),
    .row      (row_q),
    .row_bits (cells)
  );

endmodule

// File: tb/tb_silife_demo_seq.sv
// Scoreboard bench for silife_demo_seq: expected row writes and step cycles are queued by the
// stimulus; a negedge monitor pops and compares whenever wr_en or step is presented.
module tb_silife_demo_seq;

  localparam int ROWS         = 32;
  localparam int COLS         = 8;
  localparam int NUM_PATTERNS = 4;
  localparam int PERIOD_W     = 32;

  typedef struct {
    logic [4:0] row;
    logic [7:0] cells;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic        reload = 1'b0;
  logic        pause = 1'b0;
  logic [31:0] period = 32'd5;
  logic [4:0]  row_select;
  logic [7:0]  cells;
  logic        wr_en, step, busy;

  wr_t  exp_wr[$];
  int   exp_step[$];
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic en_s = 1'b0;
  logic [4:0] row_prev = '0;
  logic busy_prev = 1'b1;

  silife_demo_seq #(
    .ROWS         (ROWS),
    .COLS         (COLS),
    .NUM_PATTERNS (NUM_PATTERNS),
    .PERIOD_W     (PERIOD_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .pattern_sel (pattern_sel),
    .reload      (reload),
    .pause       (pause),
    .period      (period),
    .row_select  (row_select),
    .cells       (cells),
    .wr_en       (wr_en),
    .step        (step),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    en_s <= en;
  end

  // Row r of each pattern as written in the pattern table, then reversed onto cells.
  function automatic logic [7:0] exp_cells(input int pat, input int r);
    logic [7:0] b;
    logic [7:0] rb;
    logic [7:0] c;
    rb = r[7:0];
    case (pat)
      0:       b = rb;
      1:       b = 8'h80 >> (r % 8);
      2:       b = ~rb;
      default: b = ((r % 2) == 0) ? 8'hA5 : 8'h3C;
    endcase
    for (int i = 0; i < 8; i++) c[i] = b[7-i];
    return c;
  endfunction

  task automatic push_load(input int pat);
    wr_t w;
    for (int r = 0; r < ROWS; r++) begin
      w.row   = r[4:0];
      w.cells = exp_cells(pat, r);
      exp_wr.push_back(w);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (wr_en) begin
      checks++;
      if (exp_wr.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write at cyc %0d: row %0d, none expected", cyc, row_select);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        if (row_select !== e.row || cells !== e.cells) begin
          fails++;
          $display("FAIL row_write at cyc %0d: got row %0d cells %h, expected row %0d cells %h",
                   cyc, row_select, cells, e.row, e.cells);
        end
      end
    end
    if (step) begin
      checks++;
      if (exp_step.size() == 0) begin
        fails++;
        $display("FAIL unexpected_step at cyc %0d: none expected", cyc);
      end else begin
        int t;
        t = exp_step.pop_front();
        if (t != cyc) begin
          fails++;
          $display("FAIL step_time: got step at cyc %0d, expected cyc %0d", cyc, t);
        end
      end
    end
    checks++;
    assert (!(step && wr_en)) else begin
      fails++;
      $display("FAIL step_during_write at cyc %0d: step=%b wr_en=%b", cyc, step, wr_en);
    end
    assert (int'(row_select) <= ROWS - 1)
      else $error("FAIL row_range at cyc %0d: row %0d", cyc, row_select);
    if (rst_n && !en_s) begin
      checks++;
      assert (!wr_en && !step && row_select == row_prev && busy == busy_prev) else begin
        fails++;
        $display("FAIL en_low_hold at cyc %0d: wr_en=%b step=%b row %0d (was %0d) busy %b (was %b)",
                 cyc, wr_en, step, row_select, row_prev, busy, busy_prev);
      end
    end
    row_prev  <= row_select;
    busy_prev <= busy;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, b, d, e;
    int a1[11] = '{38, 43, 48, 60, 65, 80, 85, 91, 93, 95, 100};

    #1 rst_n = 1'b0;
    #1;
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_step", 32'(step), 32'd0);
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_row", 32'(row_select), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd1);

    // Load pattern 1 with period 5, then pause, period=0, period shrink, reload at expiry.
    c1 = cyc;
    push_load(1);
    foreach (a1[i]) exp_step.push_back(c1 + a1[i]);
    pattern_sel = 2'd1;
    en = 1'b1;
    wait_cyc(c1 + 32);
    check("last_row_busy", 32'({busy, wr_en}), 32'b11);
    wait_cyc(c1 + 33);
    check("run_entry_busy", 32'({busy, wr_en}), 32'b00);
    check("load1_drained", 32'(exp_wr.size()), 32'd0);
    wait_cyc(c1 + 50);  pause = 1'b1;
    wait_cyc(c1 + 57);  pause = 1'b0;
    wait_cyc(c1 + 66);  period = 32'd0;
    wait_cyc(c1 + 76);  period = 32'd5;
    wait_cyc(c1 + 88);  period = 32'd2;
    wait_cyc(c1 + 95);  period = 32'd5;
    wait_cyc(c1 + 104);
    push_load(1);
    reload = 1'b1;
    wait_cyc(c1 + 105);
    reload = 1'b0;
    check("reload_no_step", 32'(step), 32'd0);
    check("reload_row0", 32'({wr_en, row_select}), 32'({1'b1, 5'd0}));
    check("steps_drained", 32'(exp_step.size()), 32'd0);

    // Selection change while running starts a fresh pattern 2 load.
    wait_cyc(c1 + 140);
    b = cyc;
    push_load(2);
    pattern_sel = 2'd2;
    wait_cyc(b + 33);
    check("load2_busy", 32'(busy), 32'd0);
    check("load2_drained", 32'(exp_wr.size()), 32'd0);

    // Pattern 0 load with en gap at row 10 and selection change at row 12.
    wait_cyc(b + 36);
    d = cyc;
    push_load(0);
    push_load(2);
    pattern_sel = 2'd0;
    wait_cyc(d + 11);
    check("gap_row10", 32'(row_select), 32'd10);
    en = 1'b0;
    wait_cyc(d + 12);
    check("gap_hold_a", 32'({wr_en, row_select}), 32'({1'b0, 5'd10}));
    wait_cyc(d + 14);
    check("gap_hold_b", 32'({wr_en, row_select}), 32'({1'b0, 5'd10}));
    en = 1'b1;
    wait_cyc(d + 16);
    check("sel_change_row12", 32'(row_select), 32'd12);
    pattern_sel = 2'd2;
    wait_cyc(d + 36);
    check("load0_done", 32'({busy, wr_en}), 32'b00);
    wait_cyc(d + 37);
    check("auto_reload", 32'({busy, wr_en, row_select}), 32'({1'b1, 1'b1, 5'd0}));

    // Reset between edges at row 20 of the pattern 2 load.
    wait_cyc(d + 57);
    check("pre_reset_row20", 32'(row_select), 32'd20);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 32'({wr_en, step, busy, row_select}), 32'({1'b0, 1'b0, 1'b1, 5'd0}));
    exp_wr.delete();
    @(negedge clk);
    @(negedge clk);
    e = cyc;
    push_load(2);
    exp_step.push_back(e + 38);
    rst_n = 1'b1;
    wait_cyc(e + 1);
    check("post_reset_row0", 32'({wr_en, row_select}), 32'({1'b1, 5'd0}));
    wait_cyc(e + 40);
    check("final_wr_drained", 32'(exp_wr.size()), 32'd0);
    check("final_step_drained", 32'(exp_step.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
